// File: rtl/mo_mul_arbiter_pkg.sv
// Shared constants and helpers for the Montgomery-multiplier arbiter slice.
// Kyber field defaults; arbitration and Montgomery-constant helper functions.
package mo_mul_arbiter_pkg;

  localparam int unsigned MOD_Q             = 3329;
  localparam int unsigned DEF_DATA_WIDTH    = 12;
  localparam int unsigned DEF_MUL_STAGE_CNT = 4;

  // Widest requester vector rr_pick can search.
  localparam int unsigned RR_MAX = 32;

  typedef struct packed {
    logic        hit;
    logic [31:0] idx;
  } rr_pick_t;

  // First set bit of eligible[n-1:0] at or after ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] eligible,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned i;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      i = ptr + k;
      if (i >= n) i = i - n;
      if (k < n && !r.hit && eligible[i[4:0]]) begin
        r.hit = 1'b1;
        r.idx = i;
      end
    end
    return r;
  endfunction

  // -q^-1 mod 2^w via Newton iteration (q odd, w <= 31).
  function automatic logic [31:0] mont_qprime(input int unsigned q, input int unsigned w);
    logic [31:0] inv;
    inv = q;
    for (int unsigned i = 0; i < 5; i++) inv = inv * (32'd2 - q * inv);
    return (32'd0 - inv) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/mo_mul_arbiter_if.sv
// Requester-side bus of the shared Montgomery multiplier arbiter.
interface mo_mul_arbiter_if
  import mo_mul_arbiter_pkg::*;
#(
  parameter int unsigned REQ_CNT    = 4,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [REQ_CNT-1:0]                 req_valid;
  logic [REQ_CNT-1:0]                 req_ready;
  logic [REQ_CNT-1:0][DATA_WIDTH-1:0] req_a;
  logic [REQ_CNT-1:0][DATA_WIDTH-1:0] req_b;
  logic [REQ_CNT-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]              rsp_data;
  logic                               busy;

  modport master (output req_valid, req_a, req_b,
                  input  req_ready, rsp_valid, rsp_data, busy);
  modport slave  (input  req_valid, req_a, req_b,
                  output req_ready, rsp_valid, rsp_data, busy);
endinterface

// File: rtl/mo_mul.sv
// Pipelined Montgomery multiplier: result = a*b*2^-DATA_WIDTH mod Q after MUL_STAGE_CNT cycles.
module mo_mul
  import mo_mul_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned Q             = MOD_Q,
  parameter int unsigned MUL_STAGE_CNT = DEF_MUL_STAGE_CNT
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W-1:0] Q_PRIME = W'(mont_qprime(Q, W));

  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] t;
  logic [W-1:0]   m;
  logic [2*W:0]   u_full;
  logic [W:0]     u;
  logic [W-1:0]   redc;

  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
  end

  always_comb begin
    t      = (2*W)'(a_q) * (2*W)'(b_q);
    m      = t[W-1:0] * Q_PRIME;
    u_full = (2*W+1)'(t) + (2*W+1)'(m) * (2*W+1)'(Q);
    u      = (W+1)'(u_full >> W);
    redc   = (u >= (W+1)'(Q)) ? W'(u - (W+1)'(Q)) : u[W-1:0];
  end

  // Operand registers are stage 0; remaining stages delay the reduced value.
  if (MUL_STAGE_CNT == 1) begin : g_one
    assign result = redc;
  end else begin : g_pipe
    logic [W-1:0] res_q [MUL_STAGE_CNT-1];
    always_ff @(posedge clk) begin
      res_q[0] <= redc;
      for (int unsigned i = 1; i < MUL_STAGE_CNT - 1; i++) res_q[i] <= res_q[i-1];
    end
    assign result = res_q[MUL_STAGE_CNT-2];
  end

endmodule

// File: rtl/mo_mul_arbiter_rr.sv
// Round-robin arbiter: eligible vector to one-hot grant, pointer advances past each winner.
module rr_arbiter
  import mo_mul_arbiter_pkg::*;
#(
  parameter int unsigned REQ_CNT = 4,
  parameter int unsigned ID_W    = $clog2(REQ_CNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_CNT-1:0] eligible,
  output logic [REQ_CNT-1:0] grant,
  output logic               grant_any,
  output logic [ID_W-1:0]    grant_id
);
  logic [ID_W-1:0]   rr_ptr;
  logic [RR_MAX-1:0] elig_w;
  rr_pick_t          pick;

  always_comb begin
    elig_w                = '0;
    elig_w[REQ_CNT-1:0]   = eligible;
    pick                  = rr_pick(elig_w, 32'(rr_ptr), REQ_CNT);
    grant_any             = pick.hit;
    grant_id              = ID_W'(pick.idx);
    grant                 = '0;
    if (pick.hit) grant[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == ID_W'(REQ_CNT - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mo_mul_arbiter.sv
// Shares one mo_mul pipeline among REQ_CNT requesters; a tag shadow pipeline
// routes each result back to its owner MUL_STAGE_CNT cycles after the handshake.
module mo_mul_arbiter
  import mo_mul_arbiter_pkg::*;
#(
  parameter int unsigned REQ_CNT       = 4,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned MUL_STAGE_CNT = DEF_MUL_STAGE_CNT,
  parameter int unsigned MAX_OUT       = 4
) (
  input  logic           clk,
  input  logic           rst,
  mo_mul_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = $clog2(REQ_CNT);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [CNT_W-1:0]      out_cnt [REQ_CNT];
  logic [REQ_CNT-1:0]    eligible;
  logic [REQ_CNT-1:0]    grant;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_id;
  logic [DATA_WIDTH-1:0] mul_a, mul_b;
  tag_t                  tag_q [MUL_STAGE_CNT];
  tag_t                  tag_last;
  logic [REQ_CNT-1:0]    rsp_vld;
  logic                  any_vld;

  // Eligibility looks only at registered counts; held off entirely during reset.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      eligible[i] = rst && bus.req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .REQ_CNT (REQ_CNT),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .eligible  (eligible),
    .grant     (grant),
    .grant_any (grant_any),
    .grant_id  (grant_id)
  );

  assign bus.req_ready = grant;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (grant_any) begin
      mul_a = bus.req_a[grant_id];
      mul_b = bus.req_b[grant_id];
    end
  end

  mo_mul #(
    .DATA_WIDTH    (DATA_WIDTH),
    .Q             (MOD_Q),
    .MUL_STAGE_CNT (MUL_STAGE_CNT)
  ) u_mul (
    .clk    (clk),
    .a      (mul_a),
    .b      (mul_b),
    .result (bus.rsp_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MUL_STAGE_CNT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_t'{vld: grant_any, id: grant_id};
      for (int unsigned i = 1; i < MUL_STAGE_CNT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Outputs are masked while rst is low so nothing leaks in the cycle reset is first seen.
  always_comb begin
    tag_last = tag_q[MUL_STAGE_CNT-1];
    rsp_vld  = '0;
    any_vld  = 1'b0;
    if (rst && tag_last.vld) rsp_vld[tag_last.id] = 1'b1;
    for (int unsigned i = 0; i < MUL_STAGE_CNT; i++) any_vld = any_vld | tag_q[i].vld;
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.busy      = rst && any_vld;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      if (!rst) begin
        out_cnt[i] <= '0;
      end else if (grant[i] && !rsp_vld[i]) begin
        out_cnt[i] <= out_cnt[i] + 1'b1;
      end else if (!grant[i] && rsp_vld[i]) begin
        out_cnt[i] <= out_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REQ_CNT; i++) begin
        assert (out_cnt[i] <= CNT_W'(MAX_OUT));
        assert (!(rsp_vld[i] && out_cnt[i] == '0));
      end
    end
  end

endmodule

// File: tb/tb_mo_mul_arbiter.sv
// Randomized bench for mo_mul_arbiter against a queue-based model of in-flight operations.
module tb_mo_mul_arbiter;
  import mo_mul_arbiter_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 12;
  localparam int unsigned LAT  = 4;
  localparam int unsigned MAXO = 2;
  localparam int unsigned QQ   = 3329;

  typedef struct {
    int unsigned id;
    int unsigned a;
    int unsigned b;
    int unsigned due;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mo_mul_arbiter_if #(.REQ_CNT(N), .DATA_WIDTH(W)) bus ();

  mo_mul_arbiter #(
    .REQ_CNT       (N),
    .DATA_WIDTH    (W),
    .MUL_STAGE_CNT (LAT),
    .MAX_OUT       (MAXO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  op_t         inflight[$];
  int unsigned ptr, cyc, rinv;
  int unsigned n_tests, n_fail;
  int unsigned grant_cnt[N];
  int unsigned rsp_cnt[N];
  logic [N-1:0] vmask;
  int unsigned a_v[N];
  int unsigned b_v[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_v[i] = $urandom_range(0, QQ - 1);
      b_v[i] = $urandom_range(0, QQ - 1);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      grant_cnt[i] = 0;
      rsp_cnt[i]   = 0;
    end
  endtask

  // One clock cycle: drive, check at negedge against the model, advance the model.
  task automatic run_cycle();
    int unsigned  cnt[N];
    int unsigned  g, idx, exp_data;
    bit           hit;
    int           rsp_idx;
    logic [N-1:0] exp_ready, exp_rsp;

    bus.req_valid = vmask;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = W'(a_v[i]);
      bus.req_b[i] = W'(b_v[i]);
    end
    @(negedge clk);

    exp_ready = '0;
    exp_rsp   = '0;
    hit       = 1'b0;
    g         = 0;
    rsp_idx   = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int k = 0; k < inflight.size(); k++) begin
        cnt[inflight[k].id]++;
        if (inflight[k].due == cyc) rsp_idx = k;
      end
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (!hit && vmask[idx] && cnt[idx] < MAXO) begin
          hit = 1'b1;
          g   = idx;
        end
      end
      if (hit) exp_ready[g] = 1'b1;
      if (rsp_idx >= 0) exp_rsp[inflight[rsp_idx].id] = 1'b1;
    end

    chk("req_ready", bus.req_ready, exp_ready);
    chk("rsp_valid", bus.rsp_valid, exp_rsp);
    chk("busy", bus.busy, rst && inflight.size() > 0);
    if (rsp_idx >= 0) begin
      exp_data = ((inflight[rsp_idx].a * inflight[rsp_idx].b) % QQ) * rinv % QQ;
      chk("rsp_data", bus.rsp_data, exp_data);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i]) grant_cnt[i]++;
      if (bus.rsp_valid[i]) rsp_cnt[i]++;
    end

    if (!rst) begin
      inflight.delete();
      ptr = 0;
    end else begin
      if (rsp_idx >= 0) inflight.delete(rsp_idx);
      if (hit) begin
        inflight.push_back('{id: g, a: a_v[g], b: b_v[g], due: cyc + LAT});
        ptr = (g + 1) % N;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int unsigned total;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    ptr     = 0;
    rinv    = 0;
    for (int unsigned x = 0; x < QQ; x++) if (((1 << W) * x) % QQ == 1) rinv = x;
    clear_counts();

    // Reset with every lane requesting: nothing may be granted.
    rst   = 1'b0;
    vmask = '1;
    rand_ops();
    repeat (3) run_cycle();
    rst = 1'b1;

    // Single request a=b=1 on lane 0.
    vmask  = 4'b0001;
    a_v[0] = 1;
    b_v[0] = 1;
    run_cycle();
    vmask = '0;
    repeat (LAT + 2) run_cycle();

    // Fairness: all lanes valid for 40 cycles.
    clear_counts();
    vmask = '1;
    repeat (40) begin rand_ops(); run_cycle(); end
    vmask = '0;
    repeat (LAT + 2) run_cycle();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("fair_grants%0d", i), grant_cnt[i], 10);
      chk($sformatf("fair_rsps%0d", i), rsp_cnt[i], 10);
    end

    // Outstanding limit: lane 2 alone, 12 cycles -> grants at 0,1,5,6,10,11.
    clear_counts();
    vmask = 4'b0100;
    repeat (12) begin rand_ops(); run_cycle(); end
    vmask = '0;
    chk("limit_grants", grant_cnt[2], 6);
    repeat (LAT + 2) run_cycle();

    // Handshake coinciding with a response on lane 1.
    vmask = 4'b0010;
    rand_ops();
    run_cycle();
    vmask = '0;
    repeat (3) run_cycle();
    clear_counts();
    vmask = 4'b0010;
    repeat (8) begin rand_ops(); run_cycle(); end
    vmask = '0;
    chk("simul_grants", grant_cnt[1], 4);
    repeat (LAT + 2) run_cycle();

    // Reset with operations in flight.
    clear_counts();
    vmask = '1;
    repeat (3) begin rand_ops(); run_cycle(); end
    rst = 1'b0;
    run_cycle();
    rst   = 1'b1;
    vmask = '0;
    repeat (LAT + 2) run_cycle();
    total = 0;
    for (int i = 0; i < N; i++) total += rsp_cnt[i];
    chk("reset_discard", total, 0);
    clear_counts();
    vmask = '1;
    rand_ops();
    run_cycle();
    vmask = '0;
    chk("post_reset_grant0", grant_cnt[0], 1);
    repeat (LAT + 2) run_cycle();
    chk("post_reset_rsp0", rsp_cnt[0], 1);

    // Random sweep with occasional resets.
    repeat (3000) begin
      rand_ops();
      vmask = N'($urandom);
      if ($urandom_range(0, 1) == 0) vmask = vmask & N'($urandom);
      rst = ($urandom_range(0, 299) != 0);
      run_cycle();
    end
    rst   = 1'b1;
    vmask = '0;
    repeat (LAT + 2) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mo_mul_arbiter.md
# mo_mul_arbiter

Shares one `mo_mul` Montgomery multiplier pipeline among `REQ_CNT` requesters, such as NTT butterfly lanes and the twiddle pre-scaler. Each cycle the block grants one requester round-robin, drives its operands into the multiplier, and carries a requester tag down a shadow pipeline. The result is routed back to the owning requester exactly `MUL_STAGE_CNT` cycles after the handshake. A per-requester outstanding-operation limit prevents any one lane from monopolising the pipeline.

## Interface
- `REQ_CNT`, default 4: number of requesters. Must be 2 or more.
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: operand and result width.
- `MUL_STAGE_CNT`, default `` `MUL_STAGE_CNT ``: latency of `mo_mul`.
- `MAX_OUT`, default 4: maximum in-flight operations per requester. Must be 1 or more.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `req_valid`  in  `[REQ_CNT]`: requester i has an operand pair.
- `req_ready`  out  `[REQ_CNT]`: requester i is granted this cycle.
- `req_a`, `req_b`  in  `[REQ_CNT][DATA_WIDTH]`: operands; must be less than `Q`.
- `rsp_valid`  out  `[REQ_CNT]`: result for requester i in this cycle. One-hot or zero.
- `rsp_data`  out  `DATA_WIDTH`: a·b·2^-DATA_WIDTH mod Q. Shared by all requesters.
- `busy`  out  1: at least one operation is in flight.

## Operation
- **Eligibility:** requester i is eligible when `req_valid[i]` is high and `out_cnt[i] < MAX_OUT`. Eligibility uses only the registered count. A response arriving in the same cycle does not free a slot until the next cycle.
- **Arbitration:** combinational round-robin.
  - Search starts at `rr_ptr`; the first eligible requester wins.
  - `req_ready` is one-hot or zero and never depends on a ready from another requester.
- **Pointer update:** on a grant to requester g, `rr_ptr` becomes (g+1) mod `REQ_CNT`. It is unchanged when there is no grant.
- **Handshake:** a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high at a rising edge. The requester may hold or change its operands freely while not granted.
- **Operand drive:** the granted requester's `req_a`/`req_b` are muxed combinationally onto `mo_mul.a`/`mo_mul.b`. With no grant, both are driven to 0.
- **Tag pipeline:** `MUL_STAGE_CNT` registered stages, each holding `{vld, id}`.
  - Stage 0 loads `{grant_any, g}`.
  - The last stage produces `rsp_valid` (the one-hot decode of `id`, qualified by `vld`).
  - `rsp_data` is connected directly to `mo_mul.result`.
- **No backpressure on responses:** requesters must accept `rsp_valid` unconditionally. The multiplier pipeline never stalls.
- **Outstanding counters:** `out_cnt[i]` is `$clog2(MAX_OUT+1)` bits wide.
  - +1 on handshake, -1 on `rsp_valid[i]`, unchanged when both occur in the same cycle.
  - Never exceeds `MAX_OUT` and never underflows; assert both.
- **`busy`:** OR of all tag-stage `vld` bits.
- **Reset (`rst`=0 at an edge):**
  - `rr_ptr`=0, all tag stages cleared, all `out_cnt`=0.
  - `req_ready`=0 while `rst` is low.
  - In-flight operations are discarded; no `rsp_valid` is ever issued for them.
  - The `mo_mul` internal pipeline is not reset; results it still holds are ignored because the tags are clear.

## Timing
- Grant: same cycle as `req_valid` when eligible. Zero-cycle request-to-ready path (combinational).
- Latency: a handshake in cycle c produces `rsp_valid` in cycle c+`MUL_STAGE_CNT`.
- Throughput: one operation per cycle in aggregate.
  - A single requester with `MAX_OUT` < `MUL_STAGE_CNT`+1 is throttled to `MAX_OUT` ops per (`MUL_STAGE_CNT`+1) cycles.
- Output values during and after reset: `req_ready`=0, `rsp_valid`=0, `busy`=0. `rsp_data` is undefined while `rsp_valid`=0.
- Operands go from input pins to the `mo_mul` stage-0 registers through one mux level only. No extra register is inserted, so latency equals `MUL_STAGE_CNT` exactly.

## Structure
- **Package `mul_arb_pkg`:**
  - `tag_t` struct `{logic vld; logic [$clog2(REQ_CNT)-1:0] id;}`.
  - Function `rr_pick(eligible, ptr)` returning `{hit, idx}`.
- `Q`, `DATA_WIDTH` and `MUL_STAGE_CNT` come from `ntt_param.svh` / `mo_mul.svh`.
- **Sub-modules:**
  - `rr_arbiter` (eligible vector → one-hot grant, pointer register).
  - The existing `mo_mul`, instantiated once.
- Total RTL is about 150–250 lines, excluding `mo_mul`.

## Test plan
Configuration for all cases: `REQ_CNT`=4, Kyber parameters (`Q`=3329, `DATA_WIDTH`=12). A reference model checks rsp_data·2^12 mod Q == a·b mod Q for every response.

1. **Single request:** requester 0 only, a=1, b=1 → `req_ready[0]` in the same cycle; `rsp_valid`=4'b0001 exactly `MUL_STAGE_CNT` cycles later; (`rsp_data`·4096) mod 3329 = 1.
2. **Fairness:** all four requesters valid continuously for 40 cycles → grants cycle 0,1,2,3,0,…; each requester receives 10 responses in issue order with correct tags.
3. **Outstanding limit:** `MAX_OUT`=2, `MUL_STAGE_CNT`=4, only requester 2 valid → grants in cycles 0 and 1, none in cycles 2–4, next grant in cycle 5 (slot freed by the cycle-4 response); `out_cnt[2]` never exceeds 2.
4. **Simultaneous events:** requester 1 receives a response in the same cycle as a handshake → `out_cnt[1]` unchanged.
5. **Reset mid-flight:** issue 3 ops, pull `rst` low for 1 cycle at cycle 2 → no `rsp_valid` ever for those ops; `busy`=0 and `rr_ptr`=0 after reset; a new op completes normally.
6. **Exhaustive sweep:** random a, b in [0, 3328] on all lanes for 100k cycles → zero mismatches; `busy` matches a model of in-flight count > 0.
